// File: rtl/oci_trace_buffer_if.sv
// Trace-in / drain-out bundle between the OCI trace buffer and its neighbours.
// Master drives trace words and rd_ready. Slave returns rd_valid/rd_data.
interface oci_trace_buffer_if #(
    parameter int DATA_W = 30,
    parameter int OUT_W  = 30
);
    logic              trace_valid;
    logic [DATA_W-1:0] trace_data;
    logic              rd_ready;
    logic              rd_valid;
    logic [OUT_W-1:0]  rd_data;

    modport master (
        output trace_valid, trace_data, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  trace_valid, trace_data, rd_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/oci_trace_buffer.sv
// Circular trace capture buffer. It overwrites the oldest entry when full, then drains oldest-first after test end.
// Latency: a write shows in count one cycle later; rd_data comes combinationally from the entry at rd_ptr.
// Backpressure: capture is never stalled (overflow drops the oldest entry); drain holds rd_data while rd_ready=0. OCI_TRACE_TIMESTAMP_EN adds timestamps.
module oci_trace_buffer #(
    parameter int DATA_W = 30,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int DROP_W = 8,
    parameter int TS_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    oci_trace_buffer_if.slave    bus,
    input  logic                 test_ending,
    input  logic                 test_has_ended,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow,
    output logic [DROP_W-1:0]    drop_count,
    output logic [1:0]           state_o,
    output logic                 done
);
`ifdef OCI_TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    localparam int OUT_W = DATA_W + (TS_EN ? TS_W : 0);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               ended_seen;
    logic [OUT_W-1:0]   mem [DEPTH];
    logic [OUT_W-1:0]   entry;
    logic               wr_en, pop, rd_vld, set_ended, full;

    assign full = (count == FULL_CNT);

`ifdef OCI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts <= '0;
        else       ts <= ts + 1'b1;
    end

    assign entry = {ts, bus.trace_data};
`else
    assign entry = bus.trace_data;
`endif

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        pop       = 1'b0;
        rd_vld    = 1'b0;
        set_ended = 1'b0;
        case (state)
            CAPTURE: begin
                wr_en     = bus.trace_valid;
                set_ended = test_has_ended;
                if (test_ending || test_has_ended) state_nxt = DRAIN;
            end
            DRAIN: begin
                rd_vld    = (count != '0);
                pop       = rd_vld && bus.rd_ready;
                set_ended = test_has_ended;
                // Finish on the edge that retires the last entry, not one cycle later.
                if ((ended_seen || test_has_ended) &&
                    ((count == '0) || (pop && count == ONE_CNT)))
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: state_nxt = CAPTURE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CAPTURE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            ended_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (set_ended) ended_seen <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (full) begin
                    // Overwrite-oldest: the read side slides forward with the write side.
                    rd_ptr   <= rd_ptr + 1'b1;
                    overflow <= 1'b1;
                    if (drop_count != '1) drop_count <= drop_count + 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
        end
    end

    // Storage carries no reset; contents are only observed through count/rd_valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= entry;
    end

    assign bus.rd_valid = rd_vld;
    assign bus.rd_data  = mem[rd_ptr];
    assign state_o      = state;
    assign done         = (state == DONE);
endmodule

// File: tb/tb_oci_trace_buffer.sv
// Directed bench for oci_trace_buffer: a vector table for the basic drain plus hand sequences for the corner cases.
module tb_oci_trace_buffer;
    localparam int DATA_W = 30;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 8;
    localparam int TS_W   = 16;
`ifdef OCI_TRACE_TIMESTAMP_EN
    localparam int OUT_W = DATA_W + TS_W;
`else
    localparam int OUT_W = DATA_W;
`endif
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clk;
    logic              reset;
    logic              test_ending;
    logic              test_has_ended;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;
    logic [1:0]        state_o;
    logic              done;

    oci_trace_buffer_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    oci_trace_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .DROP_W(DROP_W), .TS_W(TS_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .count          (count),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .state_o        (state_o),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    typedef struct {
        logic              tv;
        logic [DATA_W-1:0] td;
        logic              te;
        logic              th;
        logic              rr;
        logic              e_rv;
        logic [DATA_W-1:0] e_rd;
        int                e_cnt;
        int                e_st;
        logic              e_done;
        logic              e_ovf;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(logic tv, int td, logic te, logic th, logic rr,
                                logic e_rv, int e_rd, int e_cnt, int e_st,
                                logic e_done, logic e_ovf);
        vec_t v;
        v.tv = tv; v.td = DATA_W'(td); v.te = te; v.th = th; v.rr = rr;
        v.e_rv = e_rv; v.e_rd = DATA_W'(e_rd); v.e_cnt = e_cnt; v.e_st = e_st;
        v.e_done = e_done; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic tv, input int td, input logic te, input logic th, input logic rr);
        bus.trace_valid = tv;
        bus.trace_data  = DATA_W'(td);
        test_ending     = te;
        test_has_ended  = th;
        bus.rd_ready    = rr;
    endtask

    task automatic do_reset();
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + i, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] held;
        tests = 0;
        fails = 0;

        tbl[0]  = mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 2, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 3, 0, 0, 0,  0, 0, 2, 0, 0, 0);
        tbl[3]  = mk(1, 4, 0, 0, 0,  0, 0, 3, 0, 0, 0);
        tbl[4]  = mk(1, 5, 0, 0, 0,  0, 0, 4, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0,  0, 0, 5, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 1,  1, 1, 5, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 1,  1, 2, 4, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 1,  1, 3, 3, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 1,  1, 4, 2, 1, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 1,  1, 5, 1, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 1, 1,  0, 0, 0, 2, 1, 0);

        // Reset state
        reset = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic capture of 1..5 then drain
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].tv, int'(tbl[i].td), tbl[i].te, tbl[i].th, tbl[i].rr);
            #1;
            check($sformatf("v%0d_rd_valid", i), 64'(bus.rd_valid), 64'(tbl[i].e_rv));
            check($sformatf("v%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
            check($sformatf("v%0d_state", i), 64'(state_o), 64'(tbl[i].e_st));
            check($sformatf("v%0d_done", i), 64'(done), 64'(tbl[i].e_done));
            check($sformatf("v%0d_overflow", i), 64'(overflow), 64'(tbl[i].e_ovf));
            if (tbl[i].e_rv)
                check($sformatf("v%0d_rd_data", i), 64'(bus.rd_data[DATA_W-1:0]), 64'(tbl[i].e_rd));
            @(negedge clk);
        end

        // 20 writes into 16 entries: oldest four dropped
        do_reset();
        write_n(20, 0);
        #1;
        check("ovf20_count", 64'(count), 64'd16);
        check("ovf20_overflow", 64'(overflow), 64'd1);
        check("ovf20_drop", 64'(drop_count), 64'd4);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 0, 1'b0, 1'b1, 1'b1);
            #1;
            check($sformatf("ovf20_rv%0d", i), 64'(bus.rd_valid), 64'd1);
            check($sformatf("ovf20_rd%0d", i), 64'(bus.rd_data[DATA_W-1:0]), 64'(4 + i));
            @(negedge clk);
        end
        #1;
        check("ovf20_done", 64'(done), 64'd1);
        check("ovf20_done_rv", 64'(bus.rd_valid), 64'd0);

        // Saturating drop counter
        do_reset();
        write_n(300, 100);
        #1;
        check("sat_drop", 64'(drop_count), 64'd255);
        check("sat_overflow", 64'(overflow), 64'd1);
        check("sat_count", 64'(count), 64'd16);

        // Backpressure in DRAIN; trace_valid ignored
        do_reset();
        write_n(3, 'h2A0);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        held = bus.rd_data[DATA_W-1:0];
        check("bp_first", 64'(held), 64'h2A0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 'h3FF, 1'b0, 1'b0, 1'b0);
            #1;
            check($sformatf("bp_rv%0d", i), 64'(bus.rd_valid), 64'd1);
            check($sformatf("bp_rd%0d", i), 64'(bus.rd_data[DATA_W-1:0]), 64'h2A0);
            check($sformatf("bp_cnt%0d", i), 64'(count), 64'd3);
            @(negedge clk);
        end
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        #1;
        check("bp_cnt_after", 64'(count), 64'd3);
        @(negedge clk);
        #1;
        check("bp_pop_rd", 64'(bus.rd_data[DATA_W-1:0]), 64'h2A1);
        check("bp_pop_cnt", 64'(count), 64'd2);
        check("bp_drop", 64'(drop_count), 64'd0);

        // Empty drain
        do_reset();
        drive(1'b0, 0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
            #1;
            check($sformatf("empty_rv%0d", i), 64'(bus.rd_valid), 64'd0);
            check($sformatf("empty_st%0d", i), 64'(state_o), 64'd1);
            @(negedge clk);
        end
        drive(1'b0, 0, 1'b0, 1'b1, 1'b1);
        #1;
        check("empty_rv_th", 64'(bus.rd_valid), 64'd0);
        check("empty_done_pre", 64'(done), 64'd0);
        @(negedge clk);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        #1;
        check("empty_done", 64'(done), 64'd1);
        check("empty_state", 64'(state_o), 64'd2);
        @(negedge clk);

        // Asynchronous reset mid-drain at count 7
        do_reset();
        write_n(20, 0);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
        end
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
        #1;
        check("mid_cnt_pre", 64'(count), 64'd7);
        check("mid_ovf_pre", 64'(overflow), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("mid_cnt", 64'(count), 64'd0);
        check("mid_rv", 64'(bus.rd_valid), 64'd0);
        check("mid_state", 64'(state_o), 64'd0);
        check("mid_ovf", 64'(overflow), 64'd0);
        check("mid_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

`ifdef OCI_TRACE_TIMESTAMP_EN
        begin
            logic [TS_W-1:0] ts_a;
            logic [TS_W-1:0] ts_b;
            ts_a = '0;
            for (int k = 0; k < 12; k++) begin
                drive((k == 3) || (k == 10), k, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
            end
            drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
            #1;
            check("ts_rv_a", 64'(bus.rd_valid), 64'd1);
            check("ts_data_a", 64'(bus.rd_data[DATA_W-1:0]), 64'd3);
            ts_a = bus.rd_data[OUT_W-1:DATA_W];
            @(negedge clk);
            #1;
            check("ts_data_b", 64'(bus.rd_data[DATA_W-1:0]), 64'd10);
            ts_b = bus.rd_data[OUT_W-1:DATA_W];
            check("ts_delta", 64'(TS_W'(ts_b - ts_a)), 64'd7);
            @(negedge clk);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
